// File: rtl/pkt_gen_pacer.sv
`default_nettype none
// ============================================================================
// Module   : pkt_gen_pacer
// Purpose  : Per-port pacing stage placed in front of one packet generator
//            selector input. It enforces a programmable idle gap between
//            packets, counts forwarded packets and stops after a programmed
//            packet limit. A 2-entry output FIFO buffers the words.
// Ports    : clk, reset_n        - clock, synchronous active-low reset
//            in_data/ctrl/wr     - upstream word, ctrl and write strobe
//            in_rdy              - word can be accepted this cycle
//            out_data/ctrl/wr    - word, ctrl and write strobe to selector
//            out_rdy             - selector can take a word
//            enable              - allow new packets to start
//            gap_cycles          - idle cycles between EOP and next SOP
//            max_pkts            - packet limit, 0 = unlimited
//            pkt_count, done     - packets accepted, limit reached
//            pkt_bytes           - cumulative payload bytes (optional)
// Options  : define PKT_GEN_PACER_BYTE_CNT_EN to add the pkt_bytes output
//            and its byte-counting logic.
// Revision : 1.0 - initial release
// ============================================================================
module pkt_gen_pacer #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH / 8,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   input  logic                  in_wr,
   output logic                  in_rdy,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic                  out_wr,
   input  logic                  out_rdy,
   input  logic                  enable,
   input  logic [CNT_WIDTH-1:0]  gap_cycles,
   input  logic [CNT_WIDTH-1:0]  max_pkts,
   output logic [CNT_WIDTH-1:0]  pkt_count,
   output logic                  done
`ifdef PKT_GEN_PACER_BYTE_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  pkt_bytes
`endif
);

   typedef enum logic [2:0] {
      S_WAIT_SOP = 3'd0,
      S_IN_HDR   = 3'd1,
      S_IN_PAY   = 3'd2,
      S_GAP      = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t                state;
   logic [CNT_WIDTH-1:0]  gap_cnt;
   logic                  enable_q;
   logic [CNT_WIDTH-1:0]  count_next;

   // ---------------------------------------------------------------------
   // 2-entry output FIFO
   // ---------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] fifo_data [2];
   logic [CTRL_WIDTH-1:0] fifo_ctrl [2];
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic [1:0]            fifo_cnt;
   logic                  fifo_space;
   logic                  fifo_empty;
   logic                  accept;
   logic                  drain;

   assign fifo_space = ~fifo_cnt[1];
   assign fifo_empty = (fifo_cnt == 2'd0);
   assign accept     = in_wr & in_rdy;
   assign drain      = out_wr;

   assign out_wr   = reset_n & ~fifo_empty & out_rdy;
   assign out_data = fifo_data[rd_ptr];
   assign out_ctrl = fifo_ctrl[rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         fifo_cnt <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            fifo_data[i] <= '0;
            fifo_ctrl[i] <= '0;
         end
      end else begin
         if (accept) begin
            fifo_data[wr_ptr] <= in_data;
            fifo_ctrl[wr_ptr] <= in_ctrl;
            wr_ptr            <= ~wr_ptr;
         end
         if (drain) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({accept, drain})
            2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Ready generation: only WAIT_SOP is gated by enable/done, so dropping
   // enable mid-packet never stalls a packet already in flight.
   // ---------------------------------------------------------------------
   always_comb begin
      in_rdy = 1'b0;
      case (state)
         S_WAIT_SOP: in_rdy = enable & ~done & fifo_space;
         S_IN_HDR,
         S_IN_PAY:   in_rdy = fifo_space;
         default:    in_rdy = 1'b0;
      endcase
      in_rdy = in_rdy & reset_n;
   end

   assign count_next = pkt_count + CNT_WIDTH'(1);

`ifdef PKT_GEN_PACER_BYTE_CNT_EN
   // ctrl[i] set on the EOP word means CTRL_WIDTH-i valid bytes
   // (MSB set = one byte, LSB set = full word).
   function automatic logic [CNT_WIDTH-1:0] eop_bytes(input logic [CTRL_WIDTH-1:0] c);
      logic [CNT_WIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < CTRL_WIDTH; i++) begin
         if (c[i]) v = CNT_WIDTH'(CTRL_WIDTH - i);
      end
      return v;
   endfunction

   // ctrl=0 payload words seen so far in the current packet (EOP excluded)
   logic [CNT_WIDTH-1:0] pay_cnt;
`endif

   // ---------------------------------------------------------------------
   // Pacing state machine
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= S_WAIT_SOP;
         gap_cnt   <= '0;
         enable_q  <= 1'b0;
         pkt_count <= '0;
         done      <= 1'b0;
`ifdef PKT_GEN_PACER_BYTE_CNT_EN
         pay_cnt   <= '0;
         pkt_bytes <= '0;
`endif
      end else begin
         enable_q <= enable;
         case (state)
            S_WAIT_SOP: begin
               if (accept) begin
                  state <= (in_ctrl != '0) ? S_IN_HDR : S_IN_PAY;
`ifdef PKT_GEN_PACER_BYTE_CNT_EN
                  pay_cnt <= (in_ctrl == '0) ? CNT_WIDTH'(1) : '0;
`endif
               end
            end
            S_IN_HDR: begin
               if (accept && in_ctrl == '0) begin
                  state <= S_IN_PAY;
`ifdef PKT_GEN_PACER_BYTE_CNT_EN
                  pay_cnt <= pay_cnt + CNT_WIDTH'(1);
`endif
               end
            end
            S_IN_PAY: begin
               if (accept) begin
                  if (in_ctrl == '0) begin
`ifdef PKT_GEN_PACER_BYTE_CNT_EN
                     pay_cnt <= pay_cnt + CNT_WIDTH'(1);
`endif
                  end else begin
                     // EOP: the limit is only compared here, so a limit
                     // lowered below the running count waits for wrap.
                     pkt_count <= count_next;
`ifdef PKT_GEN_PACER_BYTE_CNT_EN
                     pkt_bytes <= pkt_bytes + pay_cnt * CNT_WIDTH'(CTRL_WIDTH)
                                  + eop_bytes(in_ctrl);
`endif
                     if (max_pkts != '0 && count_next == max_pkts) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                     end else if (gap_cycles != '0) begin
                        state   <= S_GAP;
                        gap_cnt <= gap_cycles - CNT_WIDTH'(1);
                     end else begin
                        state <= S_WAIT_SOP;
                     end
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt == '0) state <= S_WAIT_SOP;
               else               gap_cnt <= gap_cnt - CNT_WIDTH'(1);
            end
            S_DONE: begin
               // Restart only on a falling edge of enable.
               if (enable_q && !enable) begin
                  state     <= S_WAIT_SOP;
                  pkt_count <= '0;
                  done      <= 1'b0;
`ifdef PKT_GEN_PACER_BYTE_CNT_EN
                  pkt_bytes <= '0;
`endif
               end
            end
            default: state <= S_WAIT_SOP;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pkt_gen_pacer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_gen_pacer
// Purpose  : Self-checking bench for pkt_gen_pacer. Every accepted input word
//            is queued in a scoreboard; a monitor pops and compares each
//            word written on out_wr, and tracks packet count / done against
//            a packet-level model. Define PKT_GEN_PACER_BYTE_CNT_EN to also
//            check pkt_bytes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_gen_pacer;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [63:0] in_data;
   logic [7:0]  in_ctrl;
   logic        in_wr;
   logic        in_rdy;
   logic [63:0] out_data;
   logic [7:0]  out_ctrl;
   logic        out_wr;
   logic        out_rdy = 1'b1;
   logic        enable;
   logic [31:0] gap_cycles;
   logic [31:0] max_pkts;
   logic [31:0] pkt_count;
   logic        done;
`ifdef PKT_GEN_PACER_BYTE_CNT_EN
   logic [31:0] pkt_bytes;
`endif

   always #5 clk = ~clk;

   pkt_gen_pacer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_data    (in_data),
      .in_ctrl    (in_ctrl),
      .in_wr      (in_wr),
      .in_rdy     (in_rdy),
      .out_data   (out_data),
      .out_ctrl   (out_ctrl),
      .out_wr     (out_wr),
      .out_rdy    (out_rdy),
      .enable     (enable),
      .gap_cycles (gap_cycles),
      .max_pkts   (max_pkts),
      .pkt_count  (pkt_count),
      .done       (done)
`ifdef PKT_GEN_PACER_BYTE_CNT_EN
      ,
      .pkt_bytes  (pkt_bytes)
`endif
   );

   typedef struct {
      logic [63:0] d;
      logic [7:0]  c;
      int          acc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   bit          chk_on = 1'b0;
   bit          lat_chk = 1'b0;
   int          rdy_mode = 0;     // 0: out_rdy=1, 1: out_rdy=0, 2: random
   logic [31:0] model_count = '0;
   bit          model_done = 1'b0;
   logic [31:0] model_bytes = '0;
   int          last_eop = -1;
   int          last_gap = 0;
   int          spacing_mode = 0; // 0: none, 1: exact, 2: minimum
   int          acc_count = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always begin
      @(posedge clk);
      #1;
      case (rdy_mode)
         0:       out_rdy = 1'b1;
         1:       out_rdy = 1'b0;
         default: out_rdy = ($urandom_range(0, 3) != 0);
      endcase
   end

   // Output monitor / scoreboard
   always @(negedge clk) begin
      if (chk_on) begin
         if (out_wr) begin
            tests++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL out_unexpected: got data=%h ctrl=%h, required no write", out_data, out_ctrl);
            end else begin
               mon_e = sb.pop_front();
               if (out_data !== mon_e.d || out_ctrl !== mon_e.c) begin
                  fails++;
                  $display("FAIL out_word: got %h/%h, required %h/%h", out_data, out_ctrl, mon_e.d, mon_e.c);
               end
               if (lat_chk) begin
                  tests++;
                  if (cyc - mon_e.acc != 1) begin
                     fails++;
                     $display("FAIL latency: got %0d, required 1", cyc - mon_e.acc);
                  end
               end
            end
         end
         tests++;
         if (pkt_count !== model_count || done !== model_done) begin
            fails++;
            $display("FAIL count_done: got count=%0d done=%b, required count=%0d done=%b",
                     pkt_count, done, model_count, model_done);
         end
`ifdef PKT_GEN_PACER_BYTE_CNT_EN
         tests++;
         if (pkt_bytes !== model_bytes) begin
            fails++;
            $display("FAIL pkt_bytes: got %0d, required %0d", pkt_bytes, model_bytes);
         end
`endif
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
      tests++;
      if (got !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, got, req);
      end
   endtask

   function automatic int valid_bytes(input logic [7:0] c);
      logic [7:0] m;
      for (int i = 0; i < 8; i++) begin
         m = 8'h80 >> i;
         if (c == m) return i + 1;
      end
      return 0;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_wr = 1'b0;
      end
   endtask

   // Offer one word; it is accepted at the posedge following a negedge
   // where in_rdy is seen high. Returns just after that posedge.
   task automatic send_word(input logic [63:0] d, input logic [7:0] c,
                            input bit sop, input bit eop);
      int  n;
      bit  ok;
      int  acc;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 300) begin
         @(negedge clk);
         if (in_rdy) begin
            in_wr   = 1'b1;
            in_data = d;
            in_ctrl = c;
            acc     = cyc;
            sb.push_back('{d: d, c: c, acc: acc});
            acc_count++;
            if (sop && last_eop >= 0 && spacing_mode != 0) begin
               tests++;
               if ((spacing_mode == 1 && acc - last_eop != last_gap + 1) ||
                   (spacing_mode == 2 && acc - last_eop <  last_gap + 1)) begin
                  fails++;
                  $display("FAIL sop_spacing: got %0d cycles, required %0d", acc - last_eop, last_gap + 1);
               end
            end
            ok = 1'b1;
            @(posedge clk);
            if (eop) begin
               model_count = model_count + 32'd1;
               if (max_pkts != 0 && model_count == max_pkts) model_done = 1'b1;
               last_eop = acc;
               last_gap = int'(gap_cycles);
            end
         end else begin
            in_wr = 1'b0;
            n++;
         end
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: got no in_rdy in 300 cycles, required accept");
      end
   endtask

   task automatic send_packet(input int nh, input int np, input logic [7:0] eop_c);
      for (int i = 0; i < nh; i++) send_word({$urandom, $urandom}, 8'hFF, i == 0, 1'b0);
      for (int i = 0; i < np - 1; i++) send_word({$urandom, $urandom}, 8'h00, 1'b0, 1'b0);
      send_word({$urandom, $urandom}, eop_c, 1'b0, 1'b1);
      model_bytes = model_bytes + 32'(8 * (np - 1) + valid_bytes(eop_c));
   endtask

   task automatic expect_done_hold();
      bit bad;
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         in_wr = 1'b0;
         if (in_rdy !== 1'b0 || done !== 1'b1) bad = 1'b1;
      end
      check("done_hold_bad", 64'(bad), 64'd0);
   endtask

   task automatic toggle_enable();
      @(negedge clk);
      in_wr  = 1'b0;
      enable = 1'b0;
      @(posedge clk);
      model_count = '0;
      model_done  = 1'b0;
      model_bytes = '0;
      @(negedge clk);
      enable = 1'b1;
      check("count_after_restart", 64'(pkt_count), 64'd0);
      check("done_after_restart", 64'(done), 64'd0);
   endtask

   initial begin
      int  base;
      bit  bad;
      reset_n    = 1'b0;
      enable     = 1'b0;
      in_wr      = 1'b0;
      in_data    = '0;
      in_ctrl    = '0;
      gap_cycles = '0;
      max_pkts   = '0;
      repeat (3) @(negedge clk);
      check("rst_in_rdy", 64'(in_rdy), 64'd0);
      check("rst_out_wr", 64'(out_wr), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
      check("rst_pkt_count", 64'(pkt_count), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      reset_n = 1'b1;
      chk_on  = 1'b1;
      enable  = 1'b1;
      idle(2);

      // Back-to-back packets, no gap: one-cycle latency, no idle between.
      lat_chk      = 1'b1;
      spacing_mode = 1;
      repeat (3) send_packet(1, 4, 8'h01);
      idle(3);
      lat_chk = 1'b0;
      check("count_b2b", 64'(pkt_count), 64'd3);

      // Programmed gap of 5 cycles.
      gap_cycles = 32'd5;
      last_eop   = -1;
      repeat (2) send_packet(1, 3, 8'h20);
      idle(8);
      check("count_gap", 64'(pkt_count), 64'd5);

      // Limit raised above the running count: two more packets then DONE.
      gap_cycles   = 32'd0;
      max_pkts     = 32'd7;
      spacing_mode = 0;
      repeat (2) send_packet(2, 2, 8'h80);
      expect_done_hold();
      toggle_enable();

      // Limit of 2 from a cleared count.
      max_pkts = 32'd2;
      repeat (2) send_packet(1, 4, 8'h04);
      expect_done_hold();
      toggle_enable();
      max_pkts = 32'd0;
      idle(2);

      // Output stall mid-packet: only two words may be buffered.
      rdy_mode = 1;
      idle(3);
      base = acc_count;
      fork
         send_packet(1, 5, 8'h10);
      join_none
      repeat (10) @(negedge clk);
      check("stall_words_buffered", 64'(acc_count - base), 64'd2);
      check("stall_in_rdy", 64'(in_rdy), 64'd0);
      rdy_mode = 0;
      wait fork;
      idle(4);

      // enable dropped mid-payload: packet completes, next SOP blocked.
      send_word({$urandom, $urandom}, 8'hFF, 1'b1, 1'b0);
      send_word({$urandom, $urandom}, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      in_wr  = 1'b0;
      enable = 1'b0;
      send_word({$urandom, $urandom}, 8'h00, 1'b0, 1'b0);
      send_word({$urandom, $urandom}, 8'h02, 1'b0, 1'b1);
      model_bytes = model_bytes + 32'(8 * 2 + 7);
      bad = 1'b0;
      repeat (10) begin
         @(negedge clk);
         in_wr = 1'b0;
         if (in_rdy !== 1'b0) bad = 1'b1;
      end
      check("sop_blocked_disabled", 64'(bad), 64'd0);
      enable = 1'b1;
`ifdef PKT_GEN_PACER_BYTE_CNT_EN
      base = int'(model_bytes);
      send_packet(1, 3, 8'h08);
      idle(2);
      check("bytes_delta_21", 64'(pkt_bytes - 32'(base)), 64'd21);
`else
      send_packet(1, 3, 8'h08);
      idle(2);
`endif

      // Randomized traffic with random back-pressure and gaps.
      rdy_mode     = 2;
      spacing_mode = 2;
      last_eop     = -1;
      for (int p = 0; p < 40; p++) begin
         idle($urandom_range(1, 3));
         gap_cycles = 32'($urandom_range(0, 4));
         send_packet($urandom_range(1, 2), $urandom_range(2, 6), 8'h80 >> $urandom_range(0, 7));
      end
      rdy_mode = 0;
      idle(1);
      for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
      check("drain_empty", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
